// File: rtl/scan_seq_pkg.sv
// -----------------------------------------------------------------------------
// scan_seq_pkg
//   Shared definitions for scan_sequencer.
//   - state_t    : FSM encoding (IDLE / BLANK / DWELL)
//   - next_slot  : circular priority search over a 4-bit slot mask
//   - first_slot : lowest active slot of a mask
// -----------------------------------------------------------------------------
package scan_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    // First set bit of mask, searched circularly starting at cur+1.
    // The loop walks offsets from the farthest (4, i.e. cur itself) down to
    // the nearest (1), so the last hit written is the closest active slot.
    // If mask is empty the result is cur; callers test mask themselves.
    function automatic logic [1:0] next_slot(input logic [3:0] mask,
                                             input logic [1:0] cur);
        logic [1:0] idx;
        next_slot = cur;
        for (int i = 4; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (mask[idx]) begin
                next_slot = idx;
            end
        end
    endfunction

    // Lowest set bit: a circular search starting just after slot 3.
    function automatic logic [1:0] first_slot(input logic [3:0] mask);
        first_slot = next_slot(mask, 2'd3);
    endfunction

endpackage

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//   Drives a 2-to-4 enable decoder. Steps a 2-bit slot index through the
//   active slots of mask (ascending, wrapping). Each slot gets BLANK_CYCLES
//   of sel_en=0 followed by DWELL_CYCLES of sel_en=1.
//
// Parameters
//   CNT_W         width of the internal cycle counter
//   DWELL_CYCLES  cycles sel_en is high per slot (>=1, < 2**CNT_W)
//   BLANK_CYCLES  cycles sel_en is low before each dwell (0 = no gap)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, begin scanning (ignored while busy)
//   stop       in   1-cycle pulse, abort scanning (highest priority)
//   mask       in   [3:0] active slots; sampled at start and slot changes
//   hold       in   freeze request (only when SCAN_SEQ_HOLD_EN is defined)
//   sel        out  [1:0] current slot index
//   sel_en     out  high during the dwell window only
//   busy       out  high whenever the FSM is not idle
//   wrap       out  1-cycle pulse when the index moves to a lower/equal slot
//   fsm_state  out  [1:0] current FSM state (debug observation)
//
// Configuration macro
//   SCAN_SEQ_HOLD_EN : adds the hold input. While hold=1 the counter, sel,
//   state and sel_en freeze and wrap is forced low; stop still wins.
//
// Control semantics
//   There is no valid/ready handshake here: start and stop are single-cycle
//   command pulses sampled on every rising edge. stop beats start, hold and
//   any slot change in the same cycle. start is only acted on in IDLE with a
//   non-empty mask. All outputs are registered.
// -----------------------------------------------------------------------------
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
`ifdef SCAN_SEQ_HOLD_EN
    input  logic       hold,
`endif
    output logic [1:0] sel,
    output logic       sel_en,
    output logic       busy,
    output logic       wrap,
    output logic [1:0] fsm_state
);

    // Terminal counts; the counter runs 0..LAST within a phase.
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    // A new slot starts in BLANK, or straight in DWELL when there is no gap.
    localparam state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? ST_DWELL : ST_BLANK;

    logic hold_act;
`ifdef SCAN_SEQ_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [1:0]        sel_q,   sel_d;
    logic              sel_en_q, sel_en_d;
    logic              busy_q,   busy_d;
    logic              wrap_q,   wrap_d;
    logic [1:0]        nxt;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        nxt     = next_slot(mask, sel_q);

        if (stop) begin
            // sel deliberately keeps its last value.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hold_act) begin
            // Everything frozen; wrap stays at its default of 0.
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (mask != 4'd0)) begin
                        sel_d   = first_slot(mask);
                        state_d = SLOT_ENTRY;
                        cnt_d   = '0;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DWELL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        // Slot boundary: mask is re-sampled only here.
                        cnt_d = '0;
                        if (mask == 4'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            sel_d   = nxt;
                            state_d = SLOT_ENTRY;
                            // Equal index covers a single active slot
                            // wrapping onto itself.
                            wrap_d  = (nxt <= sel_q);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Registered outputs follow the state being entered.
        sel_en_d = (state_d == ST_DWELL);
        busy_d   = (state_d != ST_IDLE);
    end

    assign sel       = sel_q;
    assign sel_en    = sel_en_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
    assign fsm_state = state_q;

endmodule
